// File: rtl/switch_debounce.sv
// Debounces raw DIP switch pins: 2-flop synchronizer, shared sample prescaler,
// per-bit history of STABLE_N samples, plus a sticky CPU-clearable change mask.
module switch_debounce #(
    parameter int WIDTH    = 24,
    parameter int TICK_DIV = 50000,
    parameter int STABLE_N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] switch_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] clr_mask_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] chg_o,
    output logic             any_chg_o,
    output logic             tick_o
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [WIDTH-1:0]                sync1_q;
    logic [WIDTH-1:0]                sync2_q;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic                            tick_q, tick_d;
    logic [WIDTH-1:0][STABLE_N-1:0]  hist_q, hist_d;
    logic [WIDTH-1:0]                sw_q, sw_d;
    logic [WIDTH-1:0]                chg_q, chg_d;
    logic                            any_q, any_d;
    logic [WIDTH-1:0]                accept;

    // Prescaler: tick is registered, so it lands the cycle after the wrap.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    // Acceptance looks at the history including the sample shifted in this tick.
    always_comb begin
        hist_d = hist_q;
        accept = '0;
        if (tick_q) begin
            for (int i = 0; i < WIDTH; i++) begin
                hist_d[i] = {hist_q[i][STABLE_N-2:0], sync2_q[i]};
                if ((&hist_d[i]) && !sw_q[i]) begin
                    accept[i] = 1'b1;
                end
                if (!(|hist_d[i]) && sw_q[i]) begin
                    accept[i] = 1'b1;
                end
            end
        end
        sw_d  = sw_q ^ accept;
        // A fresh acceptance overrides a clear on the same bit.
        chg_d = (chg_q & ~(clr_i ? clr_mask_i : '0)) | accept;
        any_d = |chg_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cnt_q   <= '0;
            tick_q  <= 1'b0;
            hist_q  <= '0;
            sw_q    <= '0;
            chg_q   <= '0;
            any_q   <= 1'b0;
        end else begin
            sync1_q <= switch_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            tick_q  <= tick_d;
            hist_q  <= hist_d;
            sw_q    <= sw_d;
            chg_q   <= chg_d;
            any_q   <= any_d;
        end
    end

    assign sw_o      = sw_q;
    assign chg_o     = chg_q;
    assign any_chg_o = any_q;
    assign tick_o    = tick_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: a run-length reference model predicts
// every cycle's outputs; a separate monitor compares them after each clock edge.
module tb_switch_debounce;

    localparam int W  = 24;
    localparam int TD = 4;
    localparam int SN = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] switch_i = '0;
    logic         clr_i = 1'b0;
    logic [W-1:0] clr_mask_i = '0;
    logic [W-1:0] sw_o;
    logic [W-1:0] chg_o;
    logic         any_chg_o;
    logic         tick_o;

    switch_debounce #(.WIDTH(W), .TICK_DIV(TD), .STABLE_N(SN)) dut (
        .clk        (clk),
        .rst        (rst),
        .switch_i   (switch_i),
        .clr_i      (clr_i),
        .clr_mask_i (clr_mask_i),
        .sw_o       (sw_o),
        .chg_o      (chg_o),
        .any_chg_o  (any_chg_o),
        .tick_o     (tick_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] sw;
        logic [W-1:0] chg;
        logic         any;
        logic         tick;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    // Reference model: edges since reset, pin delay line, per-bit run length.
    int           cyc;
    logic [W-1:0] dq[$];
    int           run[W];
    bit           last[W];
    logic [W-1:0] msw, mchg;
    logic         many, mtick;
    bit           auto3 = 0;
    bit           hit3  = 0;

    task automatic model_a(input logic r, input logic [W-1:0] pin, output logic [W-1:0] set);
        logic [W-1:0] samp;
        set = '0;
        if (r) begin
            cyc = 0;
            dq.delete();
            dq.push_back('0);
            dq.push_back('0);
            for (int i = 0; i < W; i++) begin
                run[i]  = SN;
                last[i] = 1'b0;
            end
            msw = '0;
        end else begin
            samp = dq.pop_front();
            dq.push_back(pin);
            cyc++;
            if (cyc > 1 && (cyc - 1) % TD == 0) begin
                for (int i = 0; i < W; i++) begin
                    if (samp[i] == last[i]) begin
                        if (run[i] < SN) run[i]++;
                    end else begin
                        last[i] = samp[i];
                        run[i]  = 1;
                    end
                    if (run[i] >= SN && last[i] != msw[i]) set[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic model_b(input logic r, input logic [W-1:0] set, input logic c, input logic [W-1:0] m);
        exp_t e;
        if (r) begin
            mchg  = '0;
            many  = 1'b0;
            mtick = 1'b0;
        end else begin
            msw   = msw ^ set;
            mchg  = (mchg & ~(c ? m : '0)) | set;
            many  = |mchg;
            mtick = (cyc % TD == 0);
        end
        e.sw = msw; e.chg = mchg; e.any = many; e.tick = mtick;
        sbq.push_back(e);
    endtask

    task automatic step(input logic r, input logic [W-1:0] s, input logic c, input logic [W-1:0] m);
        logic [W-1:0] set;
        @(negedge clk);
        model_a(r, s, set);
        if (auto3) begin
            c = set[3];
            m = 24'h000008;
            if (set[3]) begin
                auto3 = 0;
                hit3  = 1;
            end
        end
        rst        = r;
        switch_i   = s;
        clr_i      = c;
        clr_mask_i = m;
        model_b(r, set, c, m);
    endtask

    task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, ncyc, got, exp);
        end
    endtask

    // Monitor: every edge the DUT presents a new output set.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            ncyc++;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk("sw_o", sw_o, e.sw);
                chk("chg_o", chg_o, e.chg);
                chk("any_chg_o", W'(any_chg_o), W'(e.any));
                chk("tick_o", W'(tick_o), W'(e.tick));
            end
        end
    end

    initial begin
        logic [W-1:0] s;
        logic         c;
        logic [W-1:0] m;
        logic         r;

        // Reset with all switches high, then release.
        repeat (3) step(1'b1, 24'hFFFFFF, 1'b0, '0);
        repeat (2) step(1'b0, 24'h000000, 1'b0, '0);
        // Clean edge on bit 0.
        repeat (30) step(1'b0, 24'h000001, 1'b0, '0);
        // Short glitch on bit 5 must be rejected.
        repeat (6) step(1'b0, 24'h000021, 1'b0, '0);
        repeat (100) step(1'b0, 24'h000001, 1'b0, '0);
        // Accept bit 5, then partial clears.
        repeat (30) step(1'b0, 24'h000021, 1'b0, '0);
        step(1'b0, 24'h000021, 1'b1, 24'h000001);
        repeat (3) step(1'b0, 24'h000021, 1'b0, '0);
        step(1'b0, 24'h000021, 1'b1, 24'h000000);
        repeat (2) step(1'b0, 24'h000021, 1'b0, '0);
        step(1'b0, 24'h000021, 1'b1, 24'h000020);
        repeat (3) step(1'b0, 24'h000021, 1'b0, '0);
        // Clear strobe lands on the acceptance cycle of bit 3.
        auto3 = 1;
        repeat (40) step(1'b0, 24'h000029, 1'b0, '0);
        auto3 = 0;
        chk("collision_hit", W'(hit3), W'(1));
        repeat (10) step(1'b0, 24'h000029, 1'b0, '0);
        // Bit 0 toggles every 2 ticks while bit 23 steps once.
        for (int k = 0; k < 10; k++) begin
            s = 24'h800028 | ((k % 2 == 0) ? 24'h000000 : 24'h000001);
            repeat (2 * TD) step(1'b0, s, 1'b0, '0);
        end
        // Reset in the middle of a pending acceptance.
        step(1'b1, 24'h000000, 1'b0, '0);
        repeat (14) step(1'b0, 24'h800000, 1'b0, '0);
        step(1'b1, 24'h800000, 1'b0, '0);
        repeat (20) step(1'b0, 24'h000000, 1'b0, '0);
        // Randomized slow switch activity with occasional clears and resets.
        s = '0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) s = s ^ W'($urandom & $urandom & $urandom);
            c = ($urandom_range(0, 7) == 0);
            m = W'($urandom);
            r = ($urandom_range(0, 499) == 0);
            step(r, s, c, m);
        end
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", W'(sbq.size()), W'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
